// File: rtl/vec_alu_seq_pkg.sv
// Shared opcodes, FSM encoding and size defaults for the sequential vector ALU controller.
// Opcodes 0000-0010 are vector-vector; the remaining legal opcodes take the latched scalar as operand B.
package vec_alu_seq_pkg;

  localparam int VLEN_DEF = 8;
  localparam int NREG_DEF = 8;
  localparam int EW_DEF   = 8;

  localparam logic [3:0] OP_OR     = 4'b0000;
  localparam logic [3:0] OP_ADD_VV = 4'b0001;
  localparam logic [3:0] OP_SUB_VV = 4'b0010;
  localparam logic [3:0] OP_XOR_VS = 4'b0101;
  localparam logic [3:0] OP_SHL    = 4'b0110;
  localparam logic [3:0] OP_SHR    = 4'b0111;
  localparam logic [3:0] OP_ROL    = 4'b1000;
  localparam logic [3:0] OP_ROR    = 4'b1001;
  localparam logic [3:0] OP_ADD_VS = 4'b1010;
  localparam logic [3:0] OP_SUB_VS = 4'b1011;
  localparam logic [3:0] OP_VFS    = 4'b1111;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/vec_op_decode.sv
// Combinational opcode classifier: legality and whether operand B comes from the scalar.
// Zero latency; no flow control.
module vec_op_decode
  import vec_alu_seq_pkg::*;
(
  input  logic [3:0] opcode,
  output logic       legal,
  output logic       use_scalar
);

  always_comb begin
    legal      = 1'b0;
    use_scalar = 1'b0;
    unique case (opcode)
      OP_OR, OP_ADD_VV, OP_SUB_VV: begin
        legal = 1'b1;
      end
      OP_XOR_VS, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ADD_VS, OP_SUB_VS, OP_VFS: begin
        legal      = 1'b1;
        use_scalar = 1'b1;
      end
      default: begin
        legal      = 1'b0;
        use_scalar = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/vec_alu_seq.sv
// Sequences one vector instruction element by element: READ -> EXEC -> WRITE per element, then DONE.
// 3 cycles per element plus one DONE cycle; start is only accepted while idle (no queueing).
module vec_alu_seq
  import vec_alu_seq_pkg::*;
#(
  parameter  int VLEN = VLEN_DEF,
  parameter  int NREG = NREG_DEF,
  parameter  int EW   = EW_DEF,
  localparam int IW   = $clog2(VLEN),
  localparam int RW   = $clog2(NREG),
  localparam int AW   = RW + IW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [3:0]    opcode,
  input  logic [RW-1:0] vs1,
  input  logic [RW-1:0] vs2,
  input  logic [RW-1:0] vd,
  input  logic [EW-1:0] scalar,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] rf_ra_a,
  output logic [AW-1:0] rf_ra_b,
  input  logic [EW-1:0] rf_rd_a,
  input  logic [EW-1:0] rf_rd_b,
  output logic [EW-1:0] alu_a,
  output logic [EW-1:0] alu_b,
  output logic [3:0]    alu_op,
  input  logic [EW-1:0] alu_res,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [EW-1:0] rf_wd
);

  state_t        state_q, state_d;
  logic [IW-1:0] idx_q;
  logic [3:0]    op_q;
  logic [RW-1:0] vs1_q, vs2_q, vd_q;
  logic [EW-1:0] scalar_q;
  logic [EW-1:0] res_q;
  logic          legal_q;
  logic          scal_q;
  logic          dec_legal;
  logic          dec_scalar;
  logic          last_elem;
  logic          accept;

  vec_op_decode u_dec (
    .opcode     (opcode),
    .legal      (dec_legal),
    .use_scalar (dec_scalar)
  );

  assign last_elem = (idx_q == IW'(VLEN - 1));
  assign accept    = (state_q == S_IDLE) && start;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      op_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      vd_q     <= '0;
      scalar_q <= '0;
      legal_q  <= 1'b0;
      scal_q   <= 1'b0;
      res_q    <= '0;
    end else begin
      state_q <= state_d;
      // Instruction fields are captured only here, so input activity mid-instruction is harmless.
      if (accept) begin
        op_q     <= opcode;
        vs1_q    <= vs1;
        vs2_q    <= vs2;
        vd_q     <= vd;
        scalar_q <= scalar;
        legal_q  <= dec_legal;
        scal_q   <= dec_scalar;
        idx_q    <= '0;
      end
      if (state_q == S_EXEC) begin
        res_q <= alu_res;
      end
      if ((state_q == S_WRITE) && !last_elem) begin
        idx_q <= idx_q + IW'(1);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b1;
    done    = 1'b0;
    err     = 1'b0;
    rf_ra_a = '0;
    rf_ra_b = '0;
    alu_a   = '0;
    alu_b   = '0;
    alu_op  = '0;
    rf_we   = 1'b0;
    rf_wa   = '0;
    rf_wd   = '0;
    unique case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_d = dec_legal ? S_READ : S_DONE;
        end
      end
      S_READ: begin
        rf_ra_a = {vs1_q, idx_q};
        rf_ra_b = {vs2_q, idx_q};
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // Read data from the previous cycle's address is valid now.
        alu_a   = rf_rd_a;
        alu_b   = scal_q ? scalar_q : rf_rd_b;
        alu_op  = op_q;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        rf_we   = 1'b1;
        rf_wa   = {vd_q, idx_q};
        rf_wd   = res_q;
        state_d = last_elem ? S_DONE : S_READ;
      end
      S_DONE: begin
        done    = 1'b1;
        err     = !legal_q;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_vec_alu_seq.sv
// Bench for vec_alu_seq: behavioural register file and ALU around the DUT, directed table,
// multi-cycle corner sequences and randomized instructions against an element-wise model.
module tb_vec_alu_seq;

  localparam int VLEN = 8;
  localparam int NREG = 8;
  localparam int EW   = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [3:0] opcode = 4'h0;
  logic [2:0] vs1 = 3'd0, vs2 = 3'd0, vd = 3'd0;
  logic [7:0] scalar = 8'h00;
  logic       busy, done, err, rf_we;
  logic [5:0] rf_ra_a, rf_ra_b, rf_wa;
  logic [7:0] rf_rd_a, rf_rd_b, alu_a, alu_b, alu_res, rf_wd;
  logic [3:0] alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  vec_alu_seq #(.VLEN(VLEN), .NREG(NREG), .EW(EW)) dut (
    .clk(clk), .reset(reset), .start(start), .opcode(opcode),
    .vs1(vs1), .vs2(vs2), .vd(vd), .scalar(scalar),
    .busy(busy), .done(done), .err(err),
    .rf_ra_a(rf_ra_a), .rf_ra_b(rf_ra_b), .rf_rd_a(rf_rd_a), .rf_rd_b(rf_rd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_res(alu_res),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] w;
    logic [7:0]  r;
    w = {a, a};
    r = 8'h00;
    case (op)
      4'h0:       r = a | b;
      4'h1, 4'hA: r = a + b;
      4'h2, 4'hB: r = a - b;
      4'h5:       r = a ^ b;
      4'h6:       r = a << b[2:0];
      4'h7:       r = a >> b[2:0];
      4'h8: begin w = w << b[2:0]; r = w[15:8]; end
      4'h9: begin w = w >> b[2:0]; r = w[7:0]; end
      4'hF:       r = b;
      default:    r = 8'h00;
    endcase
    return r;
  endfunction

  function automatic bit is_legal(input logic [3:0] op);
    return op inside {4'h0, 4'h1, 4'h2, [4'h5:4'hB], 4'hF};
  endfunction

  // Register file with 1-cycle synchronous read, plus a bench-side preload port.
  logic [7:0] mem [NREG*VLEN];
  logic       tb_we = 1'b0;
  logic [5:0] tb_wa = 6'd0;
  logic [7:0] tb_wd = 8'h00;
  always @(posedge clk) begin
    if (rf_we) mem[rf_wa] <= rf_wd;
    else if (tb_we) mem[tb_wa] <= tb_wd;
    rf_rd_a <= mem[rf_ra_a];
    rf_rd_b <= mem[rf_ra_b];
  end
  assign alu_res = alu_f(alu_op, alu_a, alu_b);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: event counters plus logs of write cycles and the operand B seen in the preceding EXEC.
  int         wr_cnt = 0, done_cnt = 0, busy_cnt = 0, viol = 0, done_cyc = 0;
  logic       done_err = 1'b0;
  int         we_log [4096];
  logic [7:0] exb_log [4096];
  logic [7:0] pa = 8'h00, pb = 8'h00;
  logic [3:0] pop = 4'h0;
  always @(negedge clk) begin
    if (rf_we) begin
      we_log[wr_cnt % 4096]  = cyc;
      exb_log[wr_cnt % 4096] = pb;
      wr_cnt++;
    end else if (pa != 8'h00 || pb != 8'h00 || pop != 4'h0) begin
      viol++;
    end
    if (!busy && (rf_we || done || err)) viol++;
    if (err && !done) viol++;
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
    end
    pa  = alu_a;
    pb  = alu_b;
    pop = alu_op;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int r, input logic [7:0] v0, input logic [7:0] dv);
    for (int i = 0; i < VLEN; i++) begin
      tb_we = 1'b1;
      tb_wa = 6'(r * VLEN + i);
      tb_wd = v0 + dv * 8'(i);
      step();
    end
    tb_we = 1'b0;
  endtask

  task automatic preload_rand(input int r);
    for (int i = 0; i < VLEN; i++) begin
      tb_we = 1'b1;
      tb_wa = 6'(r * VLEN + i);
      tb_wd = 8'($urandom);
      step();
    end
    tb_we = 1'b0;
  endtask

  task automatic issue(input logic [3:0] op, input int a, input int b, input int d,
                       input logic [7:0] s, output int t);
    opcode = op; vs1 = 3'(a); vs2 = 3'(b); vd = 3'(d); scalar = s;
    start = 1'b1;
    t = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int d0, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 60) begin
      step();
      n++;
    end
    if (done_cnt == d0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s_timeout: got no done within 60 cycles, expected one", name);
    end
  endtask

  task automatic scramble();
    opcode = 4'($urandom); vs1 = 3'($urandom); vs2 = 3'($urandom);
    vd = 3'($urandom); scalar = 8'($urandom);
  endtask

  typedef struct {
    logic [3:0] op;
    int         a, b, d;
    logic [7:0] sc;
    logic [7:0] a0, da, b0, db;
    logic [7:0] e0, de;
    logic       err;
  } vec_t;

  vec_t       tbl [8];
  logic [7:0] snap [NREG*VLEN];
  logic [7:0] expm [NREG*VLEN];

  initial begin
    int t, d0, w0, b0, mism;
    logic [3:0] op;
    int ra, rb, rd;
    logic [7:0] s, eb;

    tbl[0] = '{4'b0001, 1, 2, 3, 8'h00, 8'd1,   8'd1,  8'd10,  8'd10, 8'd11,  8'd11, 1'b0};
    tbl[1] = '{4'b1011, 1, 2, 4, 8'h05, 8'd5,   8'd1,  8'd0,   8'd0,  8'd0,   8'd1,  1'b0};
    tbl[2] = '{4'b0000, 2, 1, 2, 8'h00, 8'h0F,  8'd0,  8'hF0,  8'd0,  8'hFF,  8'd0,  1'b0};
    tbl[3] = '{4'b1100, 1, 2, 5, 8'h00, 8'd3,   8'd1,  8'd4,   8'd1,  8'd0,   8'd0,  1'b1};
    tbl[4] = '{4'b0010, 3, 4, 5, 8'h00, 8'd100, 8'd10, 8'd1,   8'd3,  8'd99,  8'd7,  1'b0};
    tbl[5] = '{4'b1010, 6, 7, 0, 8'h03, 8'd7,   8'd2,  8'd9,   8'd0,  8'd10,  8'd2,  1'b0};
    tbl[6] = '{4'b1111, 1, 2, 6, 8'h5A, 8'd0,   8'd1,  8'd2,   8'd2,  8'h5A,  8'd0,  1'b0};
    tbl[7] = '{4'b0100, 3, 4, 7, 8'h11, 8'd1,   8'd1,  8'd1,   8'd1,  8'd0,   8'd0,  1'b1};

    // Reset state, with start held high to show reset wins.
    reset = 1'b1; start = 1'b1; opcode = 4'b0001;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done_err_we", {done, err, rf_we}, 0);
    check("rst_addr", {rf_ra_a, rf_ra_b, rf_wa}, 0);
    check("rst_alu_wd", {alu_a, alu_b, alu_op, rf_wd}, 0);
    start = 1'b0;
    reset = 1'b0;
    for (int r = 0; r < NREG; r++) preload(r, 8'h00, 8'h00);
    check("rst_no_start", busy, 0);

    // Directed table.
    for (int k = 0; k < 8; k++) begin
      preload(tbl[k].a, tbl[k].a0, tbl[k].da);
      preload(tbl[k].b, tbl[k].b0, tbl[k].db);
      for (int j = 0; j < NREG*VLEN; j++) snap[j] = mem[j];
      d0 = done_cnt; w0 = wr_cnt; b0 = busy_cnt;
      issue(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].d, tbl[k].sc, t);
      wait_done(d0, "tbl");
      check($sformatf("tbl%0d_latency", k), done_cyc - t, tbl[k].err ? 1 : 3*VLEN+1);
      check($sformatf("tbl%0d_err", k), done_err, tbl[k].err);
      check($sformatf("tbl%0d_writes", k), wr_cnt - w0, tbl[k].err ? 0 : VLEN);
      check($sformatf("tbl%0d_busy_cycles", k), busy_cnt - b0, tbl[k].err ? 1 : 3*VLEN+1);
      if (tbl[k].err) begin
        mism = 0;
        for (int j = 0; j < NREG*VLEN; j++) if (mem[j] !== snap[j]) mism++;
        check($sformatf("tbl%0d_rf_untouched", k), mism, 0);
      end else begin
        check($sformatf("tbl%0d_first_we", k), we_log[w0] - t, 3);
        check($sformatf("tbl%0d_last_we", k), we_log[w0+VLEN-1] - t, 3*VLEN);
        for (int i = 0; i < VLEN; i++) begin
          check($sformatf("tbl%0d_elem%0d", k, i), mem[tbl[k].d*VLEN+i], tbl[k].e0 + tbl[k].de * 8'(i));
          eb = (tbl[k].op >= 4'b0101) ? tbl[k].sc : tbl[k].b0 + tbl[k].db * 8'(i);
          check($sformatf("tbl%0d_alu_b%0d", k, i), exb_log[w0+i], eb);
        end
      end
    end

    // start pulses mid-instruction and in the DONE cycle, with noisy inputs throughout.
    preload(1, 8'd1, 8'd1); preload(2, 8'd10, 8'd10); preload(5, 8'h77, 8'h00);
    d0 = done_cnt; w0 = wr_cnt;
    issue(4'b0001, 1, 2, 3, 8'h00, t);
    while (cyc < t + 4) begin scramble(); step(); end
    opcode = 4'b0001; vs1 = 3'd2; vs2 = 3'd2; vd = 3'd5; start = 1'b1;
    step();
    start = 1'b0;
    while (cyc < t + 25) begin scramble(); step(); end
    opcode = 4'b0001; vs1 = 3'd2; vs2 = 3'd2; vd = 3'd5; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(d0, "ignore");
    step(); step();
    check("ignore_busy_after", busy, 0);
    check("ignore_done_count", done_cnt - d0, 1);
    check("ignore_writes", wr_cnt - w0, VLEN);
    for (int i = 0; i < VLEN; i++) check($sformatf("ignore_elem%0d", i), mem[3*VLEN+i], 8'(11*(i+1)));
    mism = 0;
    for (int i = 0; i < VLEN; i++) if (mem[5*VLEN+i] !== 8'h77) mism++;
    check("ignore_v5_untouched", mism, 0);

    // Reset mid-instruction, then a clean restart.
    preload(6, 8'h00, 8'h00);
    d0 = done_cnt; w0 = wr_cnt;
    issue(4'b0001, 1, 2, 6, 8'h00, t);
    while (cyc < t + 10) step();
    reset = 1'b1;
    step();
    check("abort_busy", busy, 0);
    check("abort_outs", {done, err, rf_we, rf_ra_a, rf_wa, alu_a, alu_b, alu_op}, 0);
    reset = 1'b0;
    check("abort_writes", wr_cnt - w0, 3);
    step(); step();
    check("abort_no_done", done_cnt - d0, 0);
    for (int i = 0; i < 3; i++) check($sformatf("abort_kept%0d", i), mem[6*VLEN+i], 8'(11*(i+1)));
    mism = 0;
    for (int i = 3; i < VLEN; i++) if (mem[6*VLEN+i] !== 8'h00) mism++;
    check("abort_unwritten", mism, 0);
    d0 = done_cnt; w0 = wr_cnt;
    issue(4'b0001, 1, 2, 6, 8'h00, t);
    wait_done(d0, "restart");
    check("restart_latency", done_cyc - t, 3*VLEN+1);
    check("restart_writes", wr_cnt - w0, VLEN);
    for (int i = 0; i < VLEN; i++) check($sformatf("restart_elem%0d", i), mem[6*VLEN+i], 8'(11*(i+1)));

    // Randomized instructions against the element-wise model.
    for (int k = 0; k < 24; k++) begin
      op = 4'($urandom_range(0, 15));
      ra = $urandom_range(0, NREG-1);
      rb = $urandom_range(0, NREG-1);
      rd = $urandom_range(0, NREG-1);
      s  = 8'($urandom);
      preload_rand(ra);
      preload_rand(rb);
      for (int j = 0; j < NREG*VLEN; j++) begin
        snap[j] = mem[j];
        expm[j] = mem[j];
      end
      if (is_legal(op))
        for (int i = 0; i < VLEN; i++)
          expm[rd*VLEN+i] = alu_f(op, snap[ra*VLEN+i], (op <= 4'h2) ? snap[rb*VLEN+i] : s);
      d0 = done_cnt; w0 = wr_cnt;
      issue(op, ra, rb, rd, s, t);
      wait_done(d0, "rand");
      check($sformatf("rand%0d_latency", k), done_cyc - t, is_legal(op) ? 3*VLEN+1 : 1);
      check($sformatf("rand%0d_err", k), done_err, !is_legal(op));
      check($sformatf("rand%0d_writes", k), wr_cnt - w0, is_legal(op) ? VLEN : 0);
      mism = 0;
      for (int j = 0; j < NREG*VLEN; j++) if (mem[j] !== expm[j]) mism++;
      check($sformatf("rand%0d_rf_mismatches", k), mism, 0);
    end

    check("idle_invariants", viol, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_alu_seq.md
VEC_ALU_SEQ -- requirements
Module: vec_alu_seq

Interface
REQ-001 Parameter VLEN, default 8: elements per vector register, power of two.
REQ-002 Parameter NREG, default 8: number of vector registers, power of two.
REQ-003 Parameter EW, default 8: element width in bits.
REQ-004 The block SHALL use one clock, `clk`; reset SHALL be synchronous and active-high, port `reset`.
REQ-005 Ports SHALL be, in order: clk in 1 clock; reset in 1 sync active-high reset; start in 1 instruction request; opcode in 4 ALU operation; vs1 in log2(NREG) source A register; vs2 in log2(NREG) source B register; vd in log2(NREG) destination register; scalar in EW scalar / offset operand; busy out 1 instruction in flight; done out 1 completion pulse; err out 1 illegal-opcode flag, valid with done; rf_ra_a out log2(NREG)+log2(VLEN) element read address A; rf_ra_b out log2(NREG)+log2(VLEN) element read address B; rf_rd_a in EW read data A; rf_rd_b in EW read data B; alu_a out EW ALU operand A; alu_b out EW ALU operand B; alu_op out 4 ALU opcode; alu_res in EW ALU result, combinational; rf_we out 1 element write enable; rf_wa out log2(NREG)+log2(VLEN) element write address; rf_wd out EW write data.

Function
REQ-006 Element address SHALL be {register, index}, with the register number in the MSBs.
REQ-007 The register file SHALL be assumed to have a 1-cycle synchronous read: address in cycle N, data valid in cycle N+1.
REQ-008 FSM states SHALL be IDLE, READ, EXEC, WRITE and DONE.
REQ-009 In IDLE with start=1, the block SHALL latch opcode, vs1, vs2, vd and scalar, clear idx to 0, and go to READ (legal opcode) or DONE (illegal opcode).
REQ-010 Legal opcodes SHALL be 0000, 0001, 0010, 0101–1011 and 1111; 0011, 0100 and 1100–1110 SHALL be illegal.
REQ-011 READ SHALL drive rf_ra_a={vs1,idx} and rf_ra_b={vs2,idx}, then go to EXEC.
REQ-012 EXEC SHALL drive alu_a=rf_rd_a and alu_op=latched opcode.
REQ-013 In EXEC, alu_b SHALL be rf_rd_b for opcodes 0000–0010 and the latched scalar for all other legal opcodes.
REQ-014 EXEC SHALL register alu_res into a result register, then go to WRITE.
REQ-015 WRITE SHALL assert rf_we=1 for exactly one cycle with rf_wa={vd,idx} and rf_wd=result register.
REQ-016 From WRITE, the block SHALL go to DONE if idx==VLEN-1; otherwise it SHALL increment idx and go to READ.
REQ-017 DONE SHALL assert done=1 for one cycle, with err=1 only if the opcode was illegal, then go to IDLE.
REQ-018 Latency: start accepted in cycle T gives the first rf_we in T+3, the last rf_we in T+3·VLEN, and done in T+3·VLEN+1 (T+25 for VLEN=8).
REQ-019 An illegal opcode SHALL produce done=1 and err=1 in T+1, with no rf_we.
REQ-020 busy SHALL be 1 in READ, EXEC, WRITE and DONE, and 0 in IDLE.
REQ-021 start SHALL be ignored whenever the FSM is not in IDLE, including the DONE cycle.
REQ-022 Latched fields SHALL NOT change mid-instruction, regardless of input activity.
REQ-023 vd equal to vs1 or vs2 SHALL be legal: each element is read before it is written, so results are element-wise correct.
REQ-024 The idx counter SHALL wrap only through the IDLE reload, never by overflow.
REQ-025 rf_we SHALL be 0 in every state except WRITE.
REQ-026 alu_a, alu_b and alu_op SHALL be 0 outside EXEC.

Reset
REQ-027 reset=1 SHALL force the following on the next edge: state=IDLE, idx=0, busy=0, done=0, err=0, rf_we=0, result register=0, all address outputs=0 and all ALU outputs=0.
REQ-028 Reset asserted mid-instruction SHALL abort it: no further rf_we, no done pulse, and already-written elements remain written.
REQ-029 Reset SHALL take priority over start in the same cycle.

Structure
REQ-030 The shared package SHALL hold the opcode constants (OP_OR, OP_ADD_VV, OP_SUB_VV, OP_XOR_VS, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ADD_VS, OP_SUB_VS, OP_VFS), the FSM state encoding, and the VLEN/NREG/EW defaults.
REQ-031 One sub-module SHALL be used: vec_op_decode (combinational), mapping opcode to legal and use_scalar.
REQ-032 The ALU SHALL be instantiated outside this block.

Verification
REQ-033 ADD_VV: v1=[1..8], v2=[10,20..80], opcode 0001, vs1=1, vs2=2, vd=3 -> v3=[11,22..88], 8 writes, done at T+25, err=0.
REQ-034 Scalar select: opcode 1011, scalar=5, v1=[5..12] -> v4=[0..7]; alu_b=5 in every EXEC cycle.
REQ-035 Illegal opcode 1100 -> done=1 and err=1 at T+1, no rf_we, busy high for exactly one cycle.
REQ-036 start pulsed at T+4 and T+25 during an instruction -> ignored; exactly 8 writes and one done.
REQ-037 Reset at T+10 -> state IDLE at T+11, exactly 3 writes occurred, no done; a new start at T+12 executes normally.
REQ-038 Aliased operands: vd=vs1=2, opcode 0000, v2 initial=[0x0F×8], v1 initial=[0xF0×8] -> v2=[0xFF×8].
